// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the SoC memory data-port arbiter.
// Imported by the bus interface, the grant logic and the arbiter top.
package soc_bus_pkg;

  localparam int BE_W       = 4;
  localparam int DATA_W     = 32;
  localparam int MAX_ADDR_W = 32;

  typedef struct packed {
    logic                  we;
    logic [BE_W-1:0]       be;
    logic [MAX_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
  } bus_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

endpackage

// File: rtl/soc_mem_if.sv
// Single-beat memory bus: command towards the slave, response back.
// The mem_* modports omit err, which only exists on the master ports.
interface soc_mem_if #(
  parameter int ADDR_W = 32
);
  import soc_bus_pkg::*;

  logic              req;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;

  modport master (
    output req, we, be, addr, wdata,
    input  rdata, ack, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output rdata, ack, err
  );

  modport mem_master (
    output req, we, be, addr, wdata,
    input  rdata, ack
  );

  modport mem_slave (
    input  req, we, be, addr, wdata,
    output rdata, ack
  );

endinterface

// File: rtl/soc_rr_arbiter2.sv
// Two-request round-robin grant decision with a last-grant register.
// Purely combinational grant; last grant moves only on the update strobe.
module soc_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic       valid,
  output logic       grant
);

  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (update) begin
      last <= served;
    end
  end

  always_comb begin
    valid = |req;
    grant = 1'b0;
    unique case (1'b1)
      (req == 2'b11): grant = ~last;
      (req == 2'b10): grant = 1'b1;
      default:        grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/soc_mem_arbiter.sv
// Two-master to one-slave arbiter for the SoC memory data port.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP.
module soc_mem_arbiter
  import soc_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  soc_mem_if.slave      m0,
  soc_mem_if.slave      m1,
  soc_mem_if.mem_master s
);

  arb_state_e        state;
  bus_cmd_t          cmd;
  bus_cmd_t          cmd0;
  bus_cmd_t          cmd1;
  logic              gnt;
  logic [TO_W-1:0]   cnt;
  logic              s_req;
  logic [1:0]        ack;
  logic [1:0]        err;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              arb_valid;
  logic              arb_grant;

  assign cmd0 = '{
    we:    m0.we,
    be:    m0.be,
    addr:  MAX_ADDR_W'(m0.addr),
    wdata: m0.wdata
  };

  assign cmd1 = '{
    we:    m1.we,
    be:    m1.be,
    addr:  MAX_ADDR_W'(m1.addr),
    wdata: m1.wdata
  };

  soc_rr_arbiter2 u_rr (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .req    ({m1.req, m0.req}),
    .update (state == RESP),
    .served (gnt),
    .valid  (arb_valid),
    .grant  (arb_grant)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      cmd    <= '0;
      gnt    <= 1'b0;
      cnt    <= '0;
      s_req  <= 1'b0;
      ack    <= '0;
      err    <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            cmd   <= arb_grant ? cmd1 : cmd0;
            gnt   <= arb_grant;
            s_req <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          s_req <= 1'b0;
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (s.ack) begin
            ack[gnt] <= 1'b1;
            err[gnt] <= 1'b0;
            if (gnt) rdata1 <= s.rdata;
            else     rdata0 <= s.rdata;
            state <= RESP;
          end else if (cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // watchdog: answer with an error and zero data
            ack[gnt] <= 1'b1;
            err[gnt] <= 1'b1;
            if (gnt) rdata1 <= '0;
            else     rdata0 <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          ack   <= '0;
          err   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m0.ack   = ack[0];
  assign m0.err   = err[0];
  assign m0.rdata = rdata0;
  assign m1.ack   = ack[1];
  assign m1.err   = err[1];
  assign m1.rdata = rdata1;

  assign s.req   = s_req;
  assign s.we    = cmd.we;
  assign s.be    = cmd.be;
  assign s.addr  = cmd.addr[ADDR_W-1:0];
  assign s.wdata = cmd.wdata;

endmodule
